// File: rtl/spi_byte_slave_if.sv
// rtl/spi_byte_slave_if.sv - SPI pin and byte-handshake bundle for spi_byte_slave
//
// Purpose: groups the SPI pins and the byte-level handshake into one bundle.
//   slave  modport: used by spi_byte_slave (pins in, miso/byte strobes out)
//   master modport: used by whatever drives the pins and supplies tx words
// Signals:
//   i_sclk, i_mosi, i_cs_n  SPI pins, asynchronous to the system clock
//   o_miso                  SPI data out pin
//   i_tx_data               next word to transmit, sampled at each load point
//   o_rx_data               last complete received word
//   o_rx_valid              1-cycle pulse, o_rx_data updated
//   o_tx_req                1-cycle pulse, i_tx_data was just loaded
//   o_frame_abort           1-cycle pulse, cs_n deasserted with a partial word
interface spi_byte_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_sclk;
    logic                  i_mosi;
    logic                  i_cs_n;
    logic                  o_miso;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_tx_req;
    logic                  o_frame_abort;

    modport slave (
        input  i_sclk, i_mosi, i_cs_n, i_tx_data,
        output o_miso, o_rx_data, o_rx_valid, o_tx_req, o_frame_abort
    );

    modport master (
        output i_sclk, i_mosi, i_cs_n, i_tx_data,
        input  o_miso, o_rx_data, o_rx_valid, o_tx_req, o_frame_abort
    );
endinterface

// File: rtl/spi_byte_slave.sv
// rtl/spi_byte_slave.sv - SPI mode-0 byte slave oversampled by the system clock
//
// Purpose: converts sclk/mosi/cs_n into single-cycle received-word strobes and
//   shifts the supplied tx word out on miso, MSB first, requesting the next word.
// Ports:
//   i_clk  system clock, all logic on the rising edge
//   i_rst  asynchronous active-high reset
//   bus    spi_byte_slave_if.slave (pins, tx word, rx word and strobes)
// DATA_WIDTH must match the DATA_WIDTH of the connected interface.
module spi_byte_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    spi_byte_slave_if.slave bus
);
    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   byte_done_q, byte_done_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_req_q, tx_req_d;
    logic                   frame_abort_q, frame_abort_d;

    logic                   s_sclk, s_mosi, s_cs_n;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   sync_filled;
    logic [DATA_WIDTH-1:0]  rx_next;

    assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
    assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
    assign s_cs_n    = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_prev_q;
    assign sclk_fall = ~s_sclk & sclk_prev_q;
    assign cs_fall   = ~s_cs_n & cs_prev_q;
    assign cs_rise   = s_cs_n & ~cs_prev_q;
    assign rx_next   = {rx_shift_q[DATA_WIDTH-2:0], s_mosi};

    // After reset the synchroniser still holds its reset value (cs_n=1) for a
    // few cycles; a pin that was already low would then look like a cs fall.
    // Frames are only accepted once cs_n has been seen high from real samples.
    assign sync_filled = (fill_q == FILL_W'(SYNC_STAGES));

    assign bus.o_miso        = (state_q == S_SHIFT) & tx_shift_q[DATA_WIDTH-1];
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_tx_req      = tx_req_q;
    assign bus.o_frame_abort = frame_abort_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
        sclk_prev_d = s_sclk;
        cs_prev_d   = s_cs_n;
        fill_d      = sync_filled ? fill_q : fill_q + FILL_W'(1);
        armed_d     = armed_q | (sync_filled & s_cs_n);
    end

    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        byte_done_d   = byte_done_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_req_d      = 1'b0;
        frame_abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // sclk edges are ignored here, including one coincident with cs_fall.
                if (cs_fall && armed_q) begin
                    tx_shift_d  = bus.i_tx_data;
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    tx_req_d    = 1'b1;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cs_rise wins over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    state_d       = S_IDLE;
                    frame_abort_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rx_data_d   = rx_next;
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = '0;
                        byte_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall after the last bit of a word is the load point.
                    if (byte_done_q) begin
                        tx_shift_d  = bus.i_tx_data;
                        byte_done_d = 1'b0;
                        tx_req_d    = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_sync_q     <= '1;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            fill_q        <= '0;
            armed_q       <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            byte_done_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_sync_q     <= cs_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            fill_q        <= fill_d;
            armed_q       <= armed_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_done_q   <= byte_done_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_req_q      <= tx_req_d;
            frame_abort_q <= frame_abort_d;
        end
    end
endmodule
